// File: rtl/nios_setup_nios2_gen2_0_cpu_oci_dct_packer_pkg.sv
// Shared constants, output-register state encoding and the atom slot helper
// for the OCI debug-compressed-trace frame packer.
package nios_setup_nios2_gen2_0_cpu_oci_dct_packer_pkg;

  localparam int unsigned ATOM_W = 2;
  localparam int unsigned ATOMS  = 15;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BUF_W  = ATOM_W * ATOMS;

  typedef enum logic {
    OutEmpty,
    OutFull
  } out_state_e;

  // Returns buf with atom written into slot idx (slot 0 = oldest, at the LSBs).
  function automatic logic [BUF_W-1:0] slot_put(input logic [BUF_W-1:0]  buf_in,
                                                input logic [CNT_W-1:0]  idx,
                                                input logic [ATOM_W-1:0] atom);
    logic [BUF_W-1:0] res;
    res = buf_in;
    res[ATOM_W*idx +: ATOM_W] = atom;
    return res;
  endfunction

endpackage

// File: rtl/nios_setup_nios2_gen2_0_cpu_oci_dct_outreg.sv
// Output frame register of the DCT packer: holds one frame and its atom count
// stable until the consumer handshakes it.
module nios_setup_nios2_gen2_0_cpu_oci_dct_outreg
  import nios_setup_nios2_gen2_0_cpu_oci_dct_packer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [BUF_W-1:0] load_buf,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             frame_ready,
  output logic             out_free,
  output logic [BUF_W-1:0] dct_buffer,
  output logic [CNT_W-1:0] dct_count,
  output logic             frame_valid
);

  out_state_e       state_q;
  logic [BUF_W-1:0] buf_q;
  logic [CNT_W-1:0] cnt_q;

  assign frame_valid = (state_q == OutFull);
  assign out_free    = !frame_valid || frame_ready;
  assign dct_buffer  = buf_q;
  assign dct_count   = cnt_q;

  // Load a new frame when the accumulator transfers; otherwise empty on handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OutEmpty;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        OutEmpty: begin
          if (load) begin
            state_q <= OutFull;
            buf_q   <= load_buf;
            cnt_q   <= load_cnt;
          end
        end
        OutFull: begin
          if (load) begin
            buf_q <= load_buf;
            cnt_q <= load_cnt;
          end else if (frame_ready) begin
            state_q <= OutEmpty;
          end
        end
        default: state_q <= OutEmpty;
      endcase
    end
  end

endmodule

// File: rtl/nios_setup_nios2_gen2_0_cpu_oci_dct_packer.sv
// OCI debug-compressed-trace packer: collects 2-bit trace atoms into 15-atom
// frames and hands them to the consumer over a valid/ready interface. Trace is
// lossy; atoms arriving when nothing can take them are dropped and flagged.
// Optional feature: define DCT_DROP_COUNT_EN for an 8-bit saturating drop_cnt port.
module nios_setup_nios2_gen2_0_cpu_oci_dct_packer
  import nios_setup_nios2_gen2_0_cpu_oci_dct_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_data,
  input  logic              flush,
  output logic              atom_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              overflow
`ifdef DCT_DROP_COUNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  logic [BUF_W-1:0] acc_buf_q, acc_buf_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             flush_pend_q, flush_pend_d;
  logic             overflow_q;

  logic             out_free;
  logic             acc_full;
  logic             accept;
  logic             drop;
  logic             load;
  logic [BUF_W-1:0] load_buf;
  logic [CNT_W-1:0] load_cnt;
  logic [BUF_W-1:0] merged;
  logic [CNT_W-1:0] post_cnt;

  // Accept/drop decision and accumulator-to-output transfer.
  always_comb begin
    acc_full     = (acc_cnt_q == CNT_W'(ATOMS));
    atom_ready   = !acc_full || out_free;
    accept       = atom_valid && atom_ready;
    drop         = atom_valid && !atom_ready;
    acc_buf_d    = acc_buf_q;
    acc_cnt_d    = acc_cnt_q;
    flush_pend_d = flush_pend_q;
    load         = 1'b0;
    load_buf     = acc_buf_q;
    load_cnt     = acc_cnt_q;
    merged       = acc_buf_q;
    post_cnt     = acc_cnt_q;

    if (acc_full) begin
      if (out_free) begin
        // Ship the held full frame; a same-cycle atom starts the next frame.
        load         = 1'b1;
        acc_buf_d    = '0;
        acc_cnt_d    = '0;
        flush_pend_d = 1'b0;
        if (accept) begin
          acc_buf_d    = slot_put('0, CNT_W'(0), atom_data);
          acc_cnt_d    = CNT_W'(1);
          flush_pend_d = flush;
        end
      end else if (flush) begin
        flush_pend_d = 1'b1;
      end
    end else begin
      merged   = accept ? slot_put(acc_buf_q, acc_cnt_q, atom_data) : acc_buf_q;
      post_cnt = acc_cnt_q + CNT_W'(accept);
      if (out_free && ((post_cnt == CNT_W'(ATOMS)) ||
                       ((flush || flush_pend_q) && (post_cnt != '0)))) begin
        load         = 1'b1;
        load_buf     = merged;
        load_cnt     = post_cnt;
        acc_buf_d    = '0;
        acc_cnt_d    = '0;
        flush_pend_d = 1'b0;
      end else begin
        acc_buf_d = merged;
        acc_cnt_d = post_cnt;
        // Only reachable with the output busy: remember the flush for later.
        if (flush && (post_cnt != '0)) begin
          flush_pend_d = 1'b1;
        end
      end
    end
  end

  // Accumulator, pending-flush and overflow-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_buf_q    <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      acc_buf_q    <= acc_buf_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= drop;
    end
  end

  assign overflow = overflow_q;

`ifdef DCT_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating dropped-atom counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  nios_setup_nios2_gen2_0_cpu_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_buf    (load_buf),
    .load_cnt    (load_cnt),
    .frame_ready (frame_ready),
    .out_free    (out_free),
    .dct_buffer  (dct_buffer),
    .dct_count   (dct_count),
    .frame_valid (frame_valid)
  );

endmodule
